// File: rtl/field_line_streamer_if.sv
// Bus between the field streamer and its ROM/consumer.
// The master side is the streamer, the slave side is the ROM plus the deinterlacer.
interface field_line_streamer_if #(
    parameter int AW = 12,
    parameter int RW = 5
);
    logic [AW-1:0] rom_addr;
    logic [7:0]    rom_q;
    logic          req;
    logic          ready;
    logic [7:0]    in_data;
    logic          pix_strobe;
    logic [RW-1:0] row_idx;
    logic          field_done;
    logic          req_err;

    modport master (
        output rom_addr, ready, in_data, pix_strobe, row_idx, field_done, req_err,
        input  rom_q, req
    );

    modport slave (
        input  rom_addr, ready, in_data, pix_strobe, row_idx, field_done, req_err,
        output rom_q, req
    );
endinterface

// File: rtl/field_line_streamer.sv
// Streams one odd field out of a synchronous field ROM, one line per consumer request.
// A one-pixel hold register hides the ROM read latency so every line is gap-free.
module field_line_streamer #(
    parameter int WIDTH = 128,
    parameter int ROWS  = 32,
    parameter int AW    = 12,
    parameter int RW    = $clog2(ROWS)
) (
    input  logic                  clk,
    input  logic                  rst,
    field_line_streamer_if.master bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        S_PRIME,
        S_W0,
        S_WAIT,
        S_STREAM,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] rom_addr_q, rom_addr_d;
    logic [AW-1:0] base_q, base_d;
    logic [CW-1:0] col_q, col_d;
    logic [7:0]    hold_q, hold_d;
    logic [7:0]    in_data_q, in_data_d;
    logic          ready_q, ready_d;
    logic          pix_strobe_q, pix_strobe_d;
    logic [RW-1:0] row_idx_q, row_idx_d;
    logic          field_done_q, field_done_d;
    logic          req_err_q, req_err_d;
    logic          req_prev_q, req_prev_d;
    logic          req_rise;

    // A level-held req is a legal way to accept every line; only a fresh
    // assertion in a state that cannot take it counts as a protocol error.
    assign req_rise = bus.req & ~req_prev_q;

    always_comb begin
        state_d      = state_q;
        rom_addr_d   = rom_addr_q;
        base_d       = base_q;
        col_d        = col_q;
        hold_d       = hold_q;
        in_data_d    = in_data_q;
        ready_d      = ready_q;
        pix_strobe_d = pix_strobe_q;
        row_idx_d    = row_idx_q;
        field_done_d = field_done_q;
        req_err_d    = req_err_q;
        req_prev_d   = bus.req;

        case (state_q)
            S_PRIME: begin
                rom_addr_d = AW'(1);
                state_d    = S_W0;
                if (req_rise) begin
                    req_err_d = 1'b1;
                end
            end
            S_W0: begin
                hold_d = bus.rom_q;
                if (row_idx_q == '0 || bus.req) begin
                    in_data_d    = bus.rom_q;
                    ready_d      = 1'b1;
                    pix_strobe_d = 1'b1;
                    rom_addr_d   = base_q + AW'(2);
                    col_d        = CW'(1);
                    state_d      = S_STREAM;
                end else begin
                    pix_strobe_d = 1'b0;
                    state_d      = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.req) begin
                    in_data_d    = hold_q;
                    pix_strobe_d = 1'b1;
                    rom_addr_d   = base_q + AW'(2);
                    col_d        = CW'(1);
                    state_d      = S_STREAM;
                end else begin
                    pix_strobe_d = 1'b0;
                end
            end
            S_STREAM: begin
                in_data_d    = bus.rom_q;
                pix_strobe_d = 1'b1;
                col_d        = col_q + CW'(1);
                rom_addr_d   = rom_addr_q + AW'(1);
                if (req_rise) begin
                    req_err_d = 1'b1;
                end
                if (col_q == CW'(WIDTH - 1)) begin
                    if (row_idx_q != RW'(ROWS - 1)) begin
                        // The ROM is already fetching pixel0 of the next line.
                        base_d     = base_q + AW'(WIDTH);
                        rom_addr_d = base_q + AW'(WIDTH) + AW'(1);
                        row_idx_d  = row_idx_q + RW'(1);
                        state_d    = S_W0;
                    end else begin
                        rom_addr_d = rom_addr_q;
                        state_d    = S_DONE;
                    end
                end
            end
            S_DONE: begin
                field_done_d = 1'b1;
                pix_strobe_d = 1'b0;
            end
            default: begin
                state_d = S_PRIME;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_PRIME;
            rom_addr_q   <= '0;
            base_q       <= '0;
            col_q        <= '0;
            hold_q       <= '0;
            in_data_q    <= '0;
            ready_q      <= 1'b0;
            pix_strobe_q <= 1'b0;
            row_idx_q    <= '0;
            field_done_q <= 1'b0;
            req_err_q    <= 1'b0;
            req_prev_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rom_addr_q   <= rom_addr_d;
            base_q       <= base_d;
            col_q        <= col_d;
            hold_q       <= hold_d;
            in_data_q    <= in_data_d;
            ready_q      <= ready_d;
            pix_strobe_q <= pix_strobe_d;
            row_idx_q    <= row_idx_d;
            field_done_q <= field_done_d;
            req_err_q    <= req_err_d;
            req_prev_q   <= req_prev_d;
        end
    end

    assign bus.rom_addr   = rom_addr_q;
    assign bus.in_data    = in_data_q;
    assign bus.ready      = ready_q;
    assign bus.pix_strobe = pix_strobe_q;
    assign bus.row_idx    = row_idx_q;
    assign bus.field_done = field_done_q;
    assign bus.req_err    = req_err_q;
endmodule
